// File: rtl/pc_fetch_controller_if.sv
// Bus bundle between the fetch controller and its memory, decode and control neighbours.
interface pc_fetch_controller_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            id_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic [XLEN-1:0] pc;
  logic            halted;
  logic            misalign_err;

  // Fetch controller side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc, halted, misalign_err,
    input  imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc, halt
  );

  // Memory / decode / control side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc, halted, misalign_err,
    output imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/pc_fetch_controller.sv
// Fetch PC sequencer: one outstanding imem request, single-entry instruction buffer,
// redirect/flush and halt handling.
module pc_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input logic                    clock,
  input logic                    reset_n,
  pc_fetch_controller_if.master  bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    HOLD   = 3'd2,
    FLUSH  = 3'd3,
    HALTED = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            halted_q, halted_d;
  logic            mis_q, mis_d;
  logic            resume;

  // Next-state and next-output computation; redirect overrides the normal flow.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    mis_d    = mis_q;
    resume   = 1'b0;

    if (bus.redirect_valid) begin
      pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
      valid_d = 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) mis_d = 1'b1;
      unique case (state_q)
        START, HOLD: resume = 1'b1;
        FETCH: begin
          if (bus.imem_ack) begin
            // Returned data is stale; restart immediately at the target.
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = pc_d;
          end else begin
            state_d = FLUSH;
          end
        end
        // An ack arriving now closes the old handshake, so the flush is done.
        FLUSH:   resume = bus.imem_ack;
        HALTED:  state_d = HALTED;
        default: state_d = START;
      endcase
    end else begin
      unique case (state_q)
        START: resume = 1'b1;
        FETCH: begin
          if (bus.imem_ack) begin
            instr_d = bus.imem_rdata;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            pc_d    = pc_q + XLEN'(PC_STEP);
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.id_ready) begin
            valid_d = 1'b0;
            resume  = 1'b1;
          end
        end
        FLUSH: resume = bus.imem_ack;
        HALTED: begin
          if (!bus.halt) begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
        default: state_d = START;
      endcase
    end

    // Transfer boundary: halt is sampled here, otherwise issue the next request.
    if (resume) begin
      if (bus.halt) begin
        state_d = HALTED;
        req_d   = 1'b0;
      end else begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = pc_d;
      end
    end

    halted_d = (state_d == HALTED);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= START;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.imem_req     = req_q;
  assign bus.imem_addr    = addr_q;
  assign bus.instr_valid  = valid_q;
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = ipc_q;
  assign bus.pc           = pc_q;
  assign bus.halted       = halted_q;
  assign bus.misalign_err = mis_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: cycle table plus hand sequences.
module tb_pc_fetch_controller;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  pc_fetch_controller_if bus_if ();

  pc_fetch_controller #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        ack;
    logic [31:0] rdata;
    logic        idr;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic [31:0] e_pc;
    logic        e_halted;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then sample after the rising edge.
  task automatic step(input logic rst_n, input logic ack, input logic [31:0] rdata,
                      input logic idr, input logic redir, input logic [31:0] rpc,
                      input logic halt);
    @(negedge clock);
    reset_n               = rst_n;
    bus_if.imem_ack       = ack;
    bus_if.imem_rdata     = rdata;
    bus_if.id_ready       = idr;
    bus_if.redirect_valid = redir;
    bus_if.redirect_pc    = rpc;
    bus_if.halt           = halt;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic valid, input logic [31:0] instr, input logic [31:0] ipc,
                         input logic [31:0] pc, input logic halted, input logic mis);
    chk({tag, ".imem_req"},     32'(bus_if.imem_req),     32'(req));
    chk({tag, ".imem_addr"},    bus_if.imem_addr,         addr);
    chk({tag, ".instr_valid"},  32'(bus_if.instr_valid),  32'(valid));
    chk({tag, ".instr"},        bus_if.instr,             instr);
    chk({tag, ".instr_pc"},     bus_if.instr_pc,          ipc);
    chk({tag, ".pc"},           bus_if.pc,                pc);
    chk({tag, ".halted"},       32'(bus_if.halted),       32'(halted));
    chk({tag, ".misalign_err"}, 32'(bus_if.misalign_err), 32'(mis));
  endtask

  function automatic vec_t mk(input logic rst_n, input logic ack, input logic [31:0] rdata,
                              input logic idr, input logic redir, input logic [31:0] rpc,
                              input logic req, input logic [31:0] addr, input logic valid,
                              input logic [31:0] instr, input logic [31:0] ipc,
                              input logic [31:0] pc);
    vec_t v;
    v.rst_n = rst_n; v.ack = ack; v.rdata = rdata; v.idr = idr; v.redir = redir;
    v.rpc = rpc; v.halt = 1'b0; v.e_req = req; v.e_addr = addr; v.e_valid = valid;
    v.e_instr = instr; v.e_ipc = ipc; v.e_pc = pc; v.e_halted = 1'b0; v.e_mis = 1'b0;
    return v;
  endfunction

  initial begin
    reset_n               = 1'b0;
    bus_if.imem_ack       = 1'b0;
    bus_if.imem_rdata     = '0;
    bus_if.id_ready       = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.halt           = 1'b0;

    // rst ack rdata idr redir rpc | req addr valid instr ipc pc
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,  0, 32'h0,        32'h0,  32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,  1, 32'h0,  0, 32'h0,        32'h0,  32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,  1, 32'h0,  0, 32'h0,        32'h0,  32'h0));
    vecs.push_back(mk(1, 1, 32'h1111_0000, 0, 0, 32'h0, 0, 32'h0,  1, 32'h1111_0000, 32'h0,  32'h4));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 32'h0,      0, 0, 32'h0,  0, 32'h0,  1, 32'h1111_0000, 32'h0,  32'h4));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,  1, 32'h4,  0, 32'h1111_0000, 32'h0,  32'h4));
    vecs.push_back(mk(1, 1, 32'h2222_0004, 1, 0, 32'h0, 0, 32'h4,  1, 32'h2222_0004, 32'h4,  32'h8));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,  1, 32'h8,  0, 32'h2222_0004, 32'h4,  32'h8));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,  1, 32'h8,  0, 32'h2222_0004, 32'h4,  32'h8));
    vecs.push_back(mk(1, 1, 32'h3333_0008, 0, 0, 32'h0, 0, 32'h8,  1, 32'h3333_0008, 32'h8,  32'hC));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h20, 1, 32'h20, 0, 32'h3333_0008, 32'h8,  32'h20));
    vecs.push_back(mk(1, 1, 32'hDEAD_BEEF, 0, 1, 32'h80, 1, 32'h80, 0, 32'h3333_0008, 32'h8, 32'h80));
    vecs.push_back(mk(1, 1, 32'h4444_0080, 0, 0, 32'h0, 0, 32'h80, 1, 32'h4444_0080, 32'h80, 32'h84));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,  1, 32'h84, 0, 32'h4444_0080, 32'h80, 32'h84));

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].ack, vecs[i].rdata, vecs[i].idr, vecs[i].redir,
           vecs[i].rpc, vecs[i].halt);
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
              vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_pc, vecs[i].e_halted, vecs[i].e_mis);
    end

    // Redirect while a fetch is in flight: old handshake completes, data dropped.
    step(0, 0, 32'h0, 0, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 1, 32'h10, 0);
    chk_all("flush_a", 1, 32'h0, 0, 32'h0, 32'h0, 32'h10, 0, 0);
    step(1, 1, 32'hCAFE_0000, 0, 0, 32'h0, 0);
    chk_all("fetch10", 1, 32'h10, 0, 32'h0, 32'h0, 32'h10, 0, 0);
    step(1, 0, 32'h0, 0, 1, 32'h200, 0);
    chk_all("flush_b0", 1, 32'h10, 0, 32'h0, 32'h0, 32'h200, 0, 0);
    for (int i = 1; i < 3; i++) begin
      step(1, 0, 32'h0, 0, 0, 32'h0, 0);
      chk_all($sformatf("flush_b%0d", i), 1, 32'h10, 0, 32'h0, 32'h0, 32'h200, 0, 0);
    end
    step(1, 1, 32'hDEAD_0010, 0, 0, 32'h0, 0);
    chk_all("after_flush", 1, 32'h200, 0, 32'h0, 32'h0, 32'h200, 0, 0);
    step(1, 1, 32'h5555_0200, 0, 0, 32'h0, 0);
    chk_all("hold200", 0, 32'h200, 1, 32'h5555_0200, 32'h200, 32'h204, 0, 0);

    // Halt raised mid-fetch: transfer completes and is consumed before halting.
    step(1, 0, 32'h0, 1, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 0, 32'h0, 1);
    chk_all("halt_fetch", 1, 32'h204, 0, 32'h5555_0200, 32'h200, 32'h204, 0, 0);
    step(1, 1, 32'h6666_0204, 0, 0, 32'h0, 1);
    chk_all("halt_ack", 0, 32'h204, 1, 32'h6666_0204, 32'h204, 32'h208, 0, 0);
    step(1, 0, 32'h0, 0, 0, 32'h0, 1);
    chk_all("halt_hold", 0, 32'h204, 1, 32'h6666_0204, 32'h204, 32'h208, 0, 0);
    step(1, 0, 32'h0, 1, 0, 32'h0, 1);
    chk_all("halted", 0, 32'h204, 0, 32'h6666_0204, 32'h204, 32'h208, 1, 0);
    step(1, 0, 32'h0, 0, 1, 32'h103, 1);
    chk_all("misalign", 0, 32'h204, 0, 32'h6666_0204, 32'h204, 32'h100, 1, 1);
    step(1, 0, 32'h0, 0, 0, 32'h0, 0);
    chk_all("unhalt", 1, 32'h100, 0, 32'h6666_0204, 32'h204, 32'h100, 0, 1);
    step(1, 1, 32'h7777_0100, 0, 0, 32'h0, 0);
    chk_all("hold100", 0, 32'h100, 1, 32'h7777_0100, 32'h100, 32'h104, 0, 1);

    // Wrap of the fetch PC at the top of the address space.
    step(1, 0, 32'h0, 1, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 0);
    chk_all("flush_wrap", 1, 32'h104, 0, 32'h7777_0100, 32'h100, 32'hFFFF_FFFC, 0, 1);
    step(1, 1, 32'hDEAD_0104, 0, 0, 32'h0, 0);
    chk_all("fetch_top", 1, 32'hFFFF_FFFC, 0, 32'h7777_0100, 32'h100, 32'hFFFF_FFFC, 0, 1);
    step(1, 1, 32'h8888_FFFC, 0, 0, 32'h0, 0);
    chk_all("wrap", 0, 32'hFFFF_FFFC, 1, 32'h8888_FFFC, 32'hFFFF_FFFC, 32'h0, 0, 1);

    // Reset in FLUSH abandons the request and restarts at RESET_PC.
    step(1, 0, 32'h0, 1, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 1, 32'h300, 0);
    chk_all("flush_rst", 1, 32'h0, 0, 32'h8888_FFFC, 32'hFFFF_FFFC, 32'h300, 0, 1);
    step(0, 1, 32'hDEAD_0000, 1, 1, 32'h444, 1);
    chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 32'h0, 0);
    chk_all("restart", 1, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
